stm_point_loader: RTL and testbench

- Controller that sequences per-transducer duty/phase loading for spatio-temporal modulation (STM).
- On each eligible UPDATE strobe from the sync block, it reads one point's TRANS_NUM {duty, phase} words from a sequence BRAM.
- It streams those words serially into the transducer drive registers, then issues a single COMMIT pulse.
- Sits between the CPU-written sequence memory and the silent/transducers datapath, in the clk_l domain.

---
 rtl/stm_point_loader.sv | 219 +++++++++++++++++++++
 tb/tb_stm_point_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/stm_point_loader.sv
// stm_point_loader: on an eligible UPDATE, streams one STM point's TRANS_NUM {duty, phase}
// words from the sequence BRAM into the drive registers, then pulses COMMIT. Optional duty ceiling: STM_DUTY_CLAMP_EN.
module stm_point_loader #(
    parameter int WIDTH       = 13,
    parameter int TRANS_NUM   = 249,
    parameter int IDX_WIDTH   = 16,
    parameter int ADDR_WIDTH  = 24,
    parameter int RAM_LATENCY = 2
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   ENABLE,
    input  logic                   UPDATE,
    input  logic [IDX_WIDTH-1:0]   SEQ_CYCLE,
    input  logic [IDX_WIDTH-1:0]   SEQ_DIV,
    output logic                   RAM_RD_EN,
    output logic [ADDR_WIDTH-1:0]  RAM_ADDR,
    input  logic [2*WIDTH-1:0]     RAM_DATA,
`ifdef STM_DUTY_CLAMP_EN
    input  logic [WIDTH-1:0]       DUTY_MAX,
`endif
    output logic                   WR_EN,
    output logic [7:0]             WR_IDX,
    output logic [WIDTH-1:0]       DUTY_OUT,
    output logic [WIDTH-1:0]       PHASE_OUT,
    output logic                   COMMIT,
    output logic                   BUSY,
    output logic [IDX_WIDTH-1:0]   SEQ_IDX,
    output logic                   OVERRUN
);

    localparam logic [7:0]            LAST_IDX     = 8'(TRANS_NUM - 1);
    localparam logic [ADDR_WIDTH-1:0] POINT_STRIDE = ADDR_WIDTH'(TRANS_NUM);
    localparam logic [IDX_WIDTH-1:0]  IDX_ONE      = IDX_WIDTH'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_COMMIT
    } state_t;

    state_t                  state_q, state_d;
    logic                    rd_en_q, rd_en_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              rd_cnt_q, rd_cnt_d;
    logic [RAM_LATENCY-1:0]  vld_q, vld_d;
    logic [7:0]              wr_cnt_q, wr_cnt_d;
    logic                    wr_en_q, wr_en_d;
    logic [7:0]              wr_idx_q, wr_idx_d;
    logic [WIDTH-1:0]        duty_q, duty_d;
    logic [WIDTH-1:0]        phase_q, phase_d;
    logic                    commit_q, commit_d;
    logic                    busy_q, busy_d;
    logic [IDX_WIDTH-1:0]    pt_q, pt_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [IDX_WIDTH-1:0]    div_cnt_q, div_cnt_d;
    logic                    overrun_q, overrun_d;

    logic [IDX_WIDTH-1:0]    eff_cycle;
    logic [IDX_WIDTH-1:0]    eff_div;
    logic                    capture;

    function automatic logic [WIDTH-1:0] clamp_duty(input logic [WIDTH-1:0] raw);
`ifdef STM_DUTY_CLAMP_EN
        return (raw > DUTY_MAX) ? DUTY_MAX : raw;
`else
        return raw;
`endif
    endfunction

    assign eff_cycle = (SEQ_CYCLE == '0) ? IDX_ONE : SEQ_CYCLE;
    assign eff_div   = (SEQ_DIV == '0) ? IDX_ONE : SEQ_DIV;
    // A disabled cycle must not disturb the held drive values.
    assign capture   = vld_q[RAM_LATENCY-1] && ENABLE;

    always_comb begin
        state_d   = state_q;
        rd_en_d   = rd_en_q;
        addr_d    = addr_q;
        rd_cnt_d  = rd_cnt_q;
        wr_cnt_d  = wr_cnt_q;
        wr_idx_d  = wr_idx_q;
        duty_d    = duty_q;
        phase_d   = phase_q;
        commit_d  = 1'b0;
        busy_d    = busy_q;
        pt_d      = pt_q;
        base_d    = base_q;
        div_cnt_d = div_cnt_q;
        overrun_d = overrun_q;

        // Read-return pipeline: RAM_DATA for a read lines up with the last valid stage.
        vld_d[0] = rd_en_q;
        for (int k = 1; k < RAM_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
        end
        wr_en_d = capture;
        if (capture) begin
            duty_d   = clamp_duty(RAM_DATA[2*WIDTH-1:WIDTH]);
            phase_d  = RAM_DATA[WIDTH-1:0];
            wr_idx_d = wr_cnt_q;
            wr_cnt_d = wr_cnt_q + 8'd1;
        end

        case (state_q)
            ST_IDLE: begin
                rd_en_d = 1'b0;
                busy_d  = 1'b0;
                if (UPDATE) begin
                    div_cnt_d = (div_cnt_q >= eff_div - IDX_ONE) ? '0 : div_cnt_q + IDX_ONE;
                    if (div_cnt_q == '0) begin
                        state_d  = ST_FETCH;
                        rd_en_d  = 1'b1;
                        addr_d   = base_q;
                        rd_cnt_d = 8'd0;
                        wr_cnt_d = 8'd0;
                        busy_d   = 1'b1;
                    end
                end
            end
            ST_FETCH: begin
                if (UPDATE) overrun_d = 1'b1;
                if (rd_cnt_q == LAST_IDX) begin
                    rd_en_d = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    rd_en_d  = 1'b1;
                    rd_cnt_d = rd_cnt_q + 8'd1;
                    addr_d   = addr_q + ADDR_WIDTH'(1);
                end
            end
            ST_DRAIN: begin
                if (UPDATE) overrun_d = 1'b1;
                if (wr_en_q && wr_idx_q == LAST_IDX) begin
                    state_d  = ST_COMMIT;
                    commit_d = 1'b1;
                end
            end
            ST_COMMIT: begin
                if (UPDATE) overrun_d = 1'b1;
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                // Index at or beyond the (possibly shrunk) cycle length wraps home.
                if (pt_q >= eff_cycle - IDX_ONE) begin
                    pt_d   = '0;
                    base_d = '0;
                end else begin
                    pt_d   = pt_q + IDX_ONE;
                    base_d = base_q + POINT_STRIDE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!ENABLE) begin
            state_d   = ST_IDLE;
            rd_en_d   = 1'b0;
            vld_d     = '0;
            wr_en_d   = 1'b0;
            commit_d  = 1'b0;
            busy_d    = 1'b0;
            pt_d      = '0;
            base_d    = '0;
            div_cnt_d = '0;
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            rd_en_q   <= 1'b0;
            addr_q    <= '0;
            rd_cnt_q  <= '0;
            vld_q     <= '0;
            wr_cnt_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_idx_q  <= '0;
            duty_q    <= '0;
            phase_q   <= '0;
            commit_q  <= 1'b0;
            busy_q    <= 1'b0;
            pt_q      <= '0;
            base_q    <= '0;
            div_cnt_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            addr_q    <= addr_d;
            rd_cnt_q  <= rd_cnt_d;
            vld_q     <= vld_d;
            wr_cnt_q  <= wr_cnt_d;
            wr_en_q   <= wr_en_d;
            wr_idx_q  <= wr_idx_d;
            duty_q    <= duty_d;
            phase_q   <= phase_d;
            commit_q  <= commit_d;
            busy_q    <= busy_d;
            pt_q      <= pt_d;
            base_q    <= base_d;
            div_cnt_q <= div_cnt_d;
            overrun_q <= overrun_d;
        end
    end

    assign RAM_RD_EN = rd_en_q;
    assign RAM_ADDR  = addr_q;
    assign WR_EN     = wr_en_q;
    assign WR_IDX    = wr_idx_q;
    assign DUTY_OUT  = duty_q;
    assign PHASE_OUT = phase_q;
    assign COMMIT    = commit_q;
    assign BUSY      = busy_q;
    assign SEQ_IDX   = pt_q;
    assign OVERRUN   = overrun_q;

endmodule

// File: tb/tb_stm_point_loader.sv
// Bench for stm_point_loader: BRAM model plus a cycle-timeline reference of each load.
module tb_stm_point_loader;

    localparam int W  = 13;
    localparam int T  = 249;
    localparam int L  = 2;
    localparam int IW = 16;
    localparam int AW = 24;
    localparam int LOAD_END = T + L + 2;

    logic          CLK = 1'b0;
    logic          RST;
    logic          ENABLE;
    logic          UPDATE;
    logic [IW-1:0] SEQ_CYCLE;
    logic [IW-1:0] SEQ_DIV;
    logic          RAM_RD_EN;
    logic [AW-1:0] RAM_ADDR;
    logic [2*W-1:0] RAM_DATA;
    logic          WR_EN;
    logic [7:0]    WR_IDX;
    logic [W-1:0]  DUTY_OUT;
    logic [W-1:0]  PHASE_OUT;
    logic          COMMIT;
    logic          BUSY;
    logic [IW-1:0] SEQ_IDX;
    logic          OVERRUN;
`ifdef STM_DUTY_CLAMP_EN
    logic [W-1:0]  duty_max = 13'd1000;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    logic [W-1:0] seed_a = '0;
    logic [W-1:0] seed_b = '0;

    // reference state
    int ld_r = -1;        // cycles since acceptance of the current load, -1 when idle
    int pt_m = 0;
    int div_m = 0;
    bit ovr_m = 1'b0;
    logic [W-1:0] last_duty = '0;
    logic [W-1:0] last_phase = '0;

    logic [2*W-1:0] ram_p [L];

    always #5 CLK = ~CLK;

    stm_point_loader #(
        .WIDTH(W), .TRANS_NUM(T), .IDX_WIDTH(IW), .ADDR_WIDTH(AW), .RAM_LATENCY(L)
    ) dut (
        .CLK(CLK), .RST(RST), .ENABLE(ENABLE), .UPDATE(UPDATE),
        .SEQ_CYCLE(SEQ_CYCLE), .SEQ_DIV(SEQ_DIV),
        .RAM_RD_EN(RAM_RD_EN), .RAM_ADDR(RAM_ADDR), .RAM_DATA(RAM_DATA),
`ifdef STM_DUTY_CLAMP_EN
        .DUTY_MAX(duty_max),
`endif
        .WR_EN(WR_EN), .WR_IDX(WR_IDX), .DUTY_OUT(DUTY_OUT), .PHASE_OUT(PHASE_OUT),
        .COMMIT(COMMIT), .BUSY(BUSY), .SEQ_IDX(SEQ_IDX), .OVERRUN(OVERRUN)
    );

    function automatic logic [2*W-1:0] mem_word(input logic [AW-1:0] a);
        logic [W-1:0] k;
        k = a[W-1:0];
        return {k ^ seed_a, ~k ^ seed_b};
    endfunction

    // BRAM with L cycles of read latency
    always @(posedge CLK) begin
        ram_p[0] <= mem_word(RAM_ADDR);
        for (int k = 1; k < L; k++) ram_p[k] <= ram_p[k-1];
    end
    assign RAM_DATA = ram_p[L-1];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [W-1:0] exp_duty(input logic [W-1:0] raw);
`ifdef STM_DUTY_CLAMP_EN
        return (raw > duty_max) ? duty_max : raw;
`else
        return raw;
`endif
    endfunction

    task automatic check_cycle();
        int r;
        bit e_rd, e_wr, e_cm, e_busy;
        int idx;
        logic [2*W-1:0] wd;
        r = ld_r;
        e_rd   = (r >= 1) && (r <= T);
        e_wr   = (r >= L + 2) && (r <= T + L + 1);
        e_cm   = (r == LOAD_END);
        e_busy = (r >= 1);
        check_val("flags{rd,wr,commit,busy,ovr}", 64'({RAM_RD_EN, WR_EN, COMMIT, BUSY, OVERRUN}),
                  64'({e_rd, e_wr, e_cm, e_busy, ovr_m}));
        check_val("seq_idx", 64'(SEQ_IDX), 64'(pt_m));
        if (e_rd) check_val("ram_addr", 64'(RAM_ADDR), 64'(pt_m * T + r - 1));
        if (e_wr) begin
            idx = r - L - 2;
            wd = mem_word(AW'(pt_m * T + idx));
            last_duty  = exp_duty(wd[2*W-1:W]);
            last_phase = wd[W-1:0];
            check_val("wr_idx", 64'(WR_IDX), 64'(idx));
        end
        check_val("duty", 64'(DUTY_OUT), 64'(last_duty));
        check_val("phase", 64'(PHASE_OUT), 64'(last_phase));
    endtask

    task automatic model_edge(input bit upd, input bit en);
        int eff_c, eff_d;
        bit start;
        eff_c = (SEQ_CYCLE == 0) ? 1 : int'(SEQ_CYCLE);
        eff_d = (SEQ_DIV == 0) ? 1 : int'(SEQ_DIV);
        start = 1'b0;
        if (!en) begin
            ld_r = -1; pt_m = 0; div_m = 0; ovr_m = 1'b0;
        end else begin
            if (upd) begin
                if (ld_r >= 1) ovr_m = 1'b1;
                else begin
                    start = (div_m == 0);
                    div_m = (div_m + 1 >= eff_d) ? 0 : div_m + 1;
                end
            end
            if (ld_r == LOAD_END) begin
                pt_m = (pt_m + 1 >= eff_c) ? 0 : pt_m + 1;
                ld_r = -1;
            end else if (ld_r >= 1) ld_r++;
            if (start) ld_r = 1;
        end
    endtask

    task automatic run_window(input int len, input int upd_a, input int upd_b,
                              input int ab_at, input int ab_len,
                              input int chg_at, input logic [IW-1:0] new_cycle);
        for (int t = 0; t < len; t++) begin
            UPDATE = (t == upd_a) || (t == upd_b);
            ENABLE = !(ab_at >= 0 && t >= ab_at && t < ab_at + ab_len);
            if (t == chg_at) SEQ_CYCLE = new_cycle;
            @(negedge CLK);
            check_cycle();
            model_edge(UPDATE, ENABLE);
            @(posedge CLK);
            #1;
            cyc++;
        end
        UPDATE = 1'b0;
        ENABLE = 1'b1;
    endtask

    initial begin
        RST = 1'b1; ENABLE = 1'b0; UPDATE = 1'b0;
        SEQ_CYCLE = 16'd4; SEQ_DIV = 16'd1;
        repeat (3) begin
            @(negedge CLK);
            check_val("reset_flags", 64'({RAM_RD_EN, WR_EN, COMMIT, BUSY, OVERRUN}), 64'(0));
            check_val("reset_outs", 64'({RAM_ADDR, WR_IDX, DUTY_OUT, PHASE_OUT, SEQ_IDX}), 64'(0));
        end
        @(posedge CLK); #1;
        RST = 1'b0;
        ENABLE = 1'b1;

        // basic load, then wrap through four points and back to point 0
        for (int i = 0; i < 5; i++) run_window(262, 0, -1, -1, 0, -1, '0);
        check_val("wrap_pt", 64'(SEQ_IDX), 64'(1));

        // divider of 3 over six strobes
        SEQ_DIV = 16'd3;
        for (int i = 0; i < 6; i++) run_window(262, 0, -1, -1, 0, -1, '0);
        SEQ_DIV = 16'd1;

        // overrun: second strobe 100 cycles in
        run_window(300, 0, 100, -1, 0, -1, '0);
        check_val("overrun_sticky", 64'(OVERRUN), 64'(1));

        // abort at cycle 150, then a fresh load from address 0
        run_window(300, 0, -1, 150, 4, -1, '0);
        run_window(262, 0, -1, -1, 0, -1, '0);

        // randomized windows
        for (int w = 0; w < 12; w++) begin
            int extra, len, ab, chg;
            SEQ_CYCLE = IW'($urandom_range(0, 5));
            SEQ_DIV   = IW'($urandom_range(0, 3));
            seed_a    = W'($urandom);
            seed_b    = W'($urandom);
`ifdef STM_DUTY_CLAMP_EN
            duty_max  = W'($urandom);
`endif
            extra = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, LOAD_END)) : -1;
            len   = 262 + ((extra > 0) ? extra : 0);
            ab    = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 20)) : -1;
            chg   = int'($urandom_range(0, len - 1));
            run_window(len, 0, extra, ab, int'($urandom_range(1, 4)), chg,
                       IW'($urandom_range(0, 5)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
